// File: rtl/sqrt_pipeline_stream.sv
// Purpose: pipelined restoring integer square root, one result bit per stage, optional round-to-nearest.
// Latency: N = DW/2 cycles from accept to o_Dout_valid; throughput one sample per clock.
// Backpressure: whole pipeline stalls in lockstep when the output is valid and not accepted; o_Din_ready = ~o_Dout_valid | i_Dout_ready.
//
// Ports:
//   i_Sys_clk, i_Rst             : clock, synchronous active-high reset
//   i_Din_valid/i_Din/i_Tag      : radicand and sideband tag in, accepted with o_Din_ready
//   o_Dout_valid/i_Dout_ready    : result handshake
//   o_Root, o_Rem, o_Tag         : root (floor or rounded), floor remainder, echoed tag
module sqrt_pipeline_stream #(
  parameter int DW       = 16,
  parameter int TW       = 8,
  parameter int ROUND_EN = 0
) (
  input  logic              i_Sys_clk,
  input  logic              i_Rst,
  input  logic              i_Din_valid,
  input  logic [DW-1:0]     i_Din,
  input  logic [TW-1:0]     i_Tag,
  output logic              o_Din_ready,
  output logic              o_Dout_valid,
  input  logic              i_Dout_ready,
  output logic [DW/2-1:0]   o_Root,
  output logic [DW/2:0]     o_Rem,
  output logic [TW-1:0]     o_Tag
);

  localparam int N = DW / 2;

  if (((DW % 2) != 0) || (DW < 4)) begin : g_bad_dw
    $error("sqrt_pipeline_stream: DW must be even and at least 4");
  end

  // Every stage moves together; there is no bubble collapsing.
  logic advance;
  assign advance     = ~o_Dout_valid | i_Dout_ready;
  assign o_Din_ready = advance;

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic          vld_q,  vld_d;
    logic [N-1:0]  root_q, root_d;
    logic [N:0]    rem_q,  rem_d;
    logic [DW-1:0] rad_q,  rad_d;
    logic [TW-1:0] tag_q,  tag_d;

    // Values presented by the predecessor (or the input port for S0).
    logic          p_vld;
    logic [N-1:0]  p_root;
    logic [N:0]    p_rem;
    logic [DW-1:0] p_rad;
    logic [TW-1:0] p_tag;

    logic [N+1:0]  r, t, diff;
    logic [N-1:0]  n_root;
    logic [N:0]    n_rem;
    logic          round_up;
    logic          unused_bits;

    if (k == 0) begin : g_first
      assign p_vld  = i_Din_valid;
      assign p_root = '0;
      assign p_rem  = '0;
      assign p_rad  = i_Din;
      assign p_tag  = i_Tag;
    end else begin : g_next
      assign p_vld  = g_stage[k-1].vld_q;
      assign p_root = g_stage[k-1].root_q;
      assign p_rem  = g_stage[k-1].rem_q;
      assign p_rad  = g_stage[k-1].rad_q;
      assign p_tag  = g_stage[k-1].tag_q;
    end

    // Entering stage k the partial root has k bits and rem <= 2*root < 2^(k+1),
    // so the top bits dropped below are always zero and N+2 bits hold r, t and r-t.
    assign unused_bits = ^{p_rem[N], p_root[N-1], r[N+1], diff[N+1], rad_q};

    always_comb begin
      r    = {p_rem[N-1:0], p_rad[DW-1:DW-2]};
      t    = {p_root, 2'b01};
      diff = r - t;
      if (r >= t) begin
        n_rem  = diff[N:0];
        n_root = {p_root[N-2:0], 1'b1};
      end else begin
        n_rem  = r[N:0];
        n_root = {p_root[N-2:0], 1'b0};
      end

      // Round-to-nearest folded into the last stage: x - f^2 > f means x is
      // past the midpoint (f+0.5)^2; an all-ones root saturates instead of wrapping.
      round_up = 1'b0;
      if ((ROUND_EN != 0) && (k == N-1)) begin
        round_up = (n_rem > {1'b0, n_root}) && (n_root != {N{1'b1}});
      end

      vld_d  = vld_q;
      root_d = root_q;
      rem_d  = rem_q;
      rad_d  = rad_q;
      tag_d  = tag_q;
      if (advance) begin
        vld_d  = p_vld;
        root_d = n_root + {{(N-1){1'b0}}, round_up};
        rem_d  = n_rem;
        rad_d  = {p_rad[DW-3:0], 2'b00};
        tag_d  = p_tag;
      end
    end

    always_ff @(posedge i_Sys_clk) begin
      if (i_Rst) begin
        vld_q  <= 1'b0;
        root_q <= '0;
        rem_q  <= '0;
        rad_q  <= '0;
        tag_q  <= '0;
      end else begin
        vld_q  <= vld_d;
        root_q <= root_d;
        rem_q  <= rem_d;
        rad_q  <= rad_d;
        tag_q  <= tag_d;
      end
    end
  end

  assign o_Dout_valid = g_stage[N-1].vld_q;
  assign o_Root       = g_stage[N-1].root_q;
  assign o_Rem        = g_stage[N-1].rem_q;
  assign o_Tag        = g_stage[N-1].tag_q;

endmodule

// File: tb/tb_sqrt_pipeline_stream.sv
// Bench for sqrt_pipeline_stream: DW=16 floor and round builds in lockstep, plus DW=8 and DW=32 builds.
// Reference: binary-search integer square root on plain integers; scoreboard queues of accepted samples.
module tb_sqrt_pipeline_stream;

  typedef struct {
    longint unsigned din;
    logic [7:0]      tag;
  } smp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string nm, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, obs, obs, exp_v, exp_v);
  endtask

  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic longint unsigned round_root(input longint unsigned x, input int n);
    longint unsigned f;
    f = isqrt(x);
    if ((x - f * f > f) && (f != (64'd1 << n) - 1)) return f + 1;
    return f;
  endfunction

  // ---------------- DW=16 floor + round instances (shared stimulus) ----------------
  logic        rst = 1'b1;
  logic        din_vld, dout_rdy;
  logic [15:0] din;
  logic [7:0]  tag;
  logic        din_rdy, dout_vld, r_din_rdy, r_dout_vld;
  logic [7:0]  root, r_root, otag, r_tag;
  logic [8:0]  rem, r_rem;

  sqrt_pipeline_stream #(.DW(16), .TW(8), .ROUND_EN(0)) u_dut (
    .i_Sys_clk(clk), .i_Rst(rst), .i_Din_valid(din_vld), .i_Din(din), .i_Tag(tag),
    .o_Din_ready(din_rdy), .o_Dout_valid(dout_vld), .i_Dout_ready(dout_rdy),
    .o_Root(root), .o_Rem(rem), .o_Tag(otag));

  sqrt_pipeline_stream #(.DW(16), .TW(8), .ROUND_EN(1)) u_rnd (
    .i_Sys_clk(clk), .i_Rst(rst), .i_Din_valid(din_vld), .i_Din(din), .i_Tag(tag),
    .o_Din_ready(r_din_rdy), .o_Dout_valid(r_dout_vld), .i_Dout_ready(dout_rdy),
    .o_Root(r_root), .o_Rem(r_rem), .o_Tag(r_tag));

  // ---------------- DW=8 and DW=32 instances ----------------
  logic        rst_aux = 1'b1;
  logic        aux_rdy = 1'b1;
  logic        d8_vld, d8_irdy, d8_ovld, d32_vld, d32_irdy, d32_ovld;
  logic [7:0]  d8_din, d8_tag, d8_otag, d32_tag, d32_otag;
  logic [3:0]  d8_root;
  logic [4:0]  d8_rem;
  logic [31:0] d32_din;
  logic [15:0] d32_root;
  logic [16:0] d32_rem;

  sqrt_pipeline_stream #(.DW(8), .TW(8), .ROUND_EN(0)) u_d8 (
    .i_Sys_clk(clk), .i_Rst(rst_aux), .i_Din_valid(d8_vld), .i_Din(d8_din), .i_Tag(d8_tag),
    .o_Din_ready(d8_irdy), .o_Dout_valid(d8_ovld), .i_Dout_ready(aux_rdy),
    .o_Root(d8_root), .o_Rem(d8_rem), .o_Tag(d8_otag));

  sqrt_pipeline_stream #(.DW(32), .TW(8), .ROUND_EN(0)) u_d32 (
    .i_Sys_clk(clk), .i_Rst(rst_aux), .i_Din_valid(d32_vld), .i_Din(d32_din), .i_Tag(d32_tag),
    .o_Din_ready(d32_irdy), .o_Dout_valid(d32_ovld), .i_Dout_ready(aux_rdy),
    .o_Root(d32_root), .o_Rem(d32_rem), .o_Tag(d32_otag));

  // ---------------- DW=16 monitor / scoreboard ----------------
  smp_t       sb[$];
  int         cyc = 0, out_cnt = 0, n_extra = 0;
  int         first_out_cyc = -1, last_out_cyc = -1;
  logic       prev_stall = 1'b0;
  logic [7:0] s_root, s_rroot, s_tag;
  logic [8:0] s_rem;

  always @(negedge clk) begin
    smp_t            s;
    logic            exp_rdy;
    longint unsigned f;
    cyc++;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      exp_rdy = !dout_vld || dout_rdy;
      check_val("din_ready", din_rdy, exp_rdy);
      check_val("rnd_din_ready", r_din_rdy, exp_rdy);
      check_val("rnd_valid", r_dout_vld, dout_vld);
      if (prev_stall) begin
        check_val("stall_valid", dout_vld, 1);
        check_val("stall_root", root, s_root);
        check_val("stall_rem", rem, s_rem);
        check_val("stall_tag", otag, s_tag);
        check_val("stall_rnd_root", r_root, s_rroot);
      end
      if (dout_vld && dout_rdy) begin
        if (sb.size() == 0) n_extra++;
        else begin
          s = sb.pop_front();
          f = isqrt(s.din);
          check_val("root", root, f);
          check_val("rem", rem, s.din - f * f);
          check_val("tag", otag, s.tag);
          check_val("rem_bound", (rem <= 2 * root), 1);
          check_val("rnd_root", r_root, round_root(s.din, 8));
          check_val("rnd_rem", r_rem, s.din - f * f);
          check_val("rnd_tag", r_tag, s.tag);
        end
        out_cnt++;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
      if (din_vld && din_rdy) begin
        s.din = din;
        s.tag = tag;
        sb.push_back(s);
      end
      prev_stall = dout_vld && !dout_rdy;
      s_root  = root;
      s_rem   = rem;
      s_tag   = otag;
      s_rroot = r_root;
    end
  end

  // Called #1 after the accept edge; the result must show after N-1 = 7 further edges.
  task automatic wait_result(input string nm);
    int lat;
    lat = 0;
    while (!dout_vld && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val({nm, "_latency"}, lat, 7);
  endtask

  task automatic single(input logic [15:0] x, input logic [7:0] tg, input logic [7:0] e_root,
                        input logic [8:0] e_rem, input logic [7:0] e_rnd, input string nm);
    @(posedge clk); #1;
    din_vld = 1'b1; din = x; tag = tg; dout_rdy = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
    wait_result(nm);
    check_val({nm, "_root"}, root, e_root);
    check_val({nm, "_rem"}, rem, e_rem);
    check_val({nm, "_tag"}, otag, tg);
    check_val({nm, "_rnd_root"}, r_root, e_rnd);
    @(posedge clk); #1;
  endtask

  // ---------------- aux monitors ----------------
  smp_t q8[$], q32[$];
  int   d8_cnt = 0, d32_cnt = 0, d32_sent = 0;
  logic aux_done = 1'b0;

  always @(negedge clk) begin
    smp_t            s;
    longint unsigned f;
    if (!rst_aux) begin
      if (d8_ovld) begin
        d8_cnt++;
        if (q8.size() != 0) begin
          s = q8.pop_front();
          f = isqrt(s.din);
          check_val("d8_root", d8_root, f);
          check_val("d8_rem", d8_rem, s.din - f * f);
          check_val("d8_tag", d8_otag, s.tag);
        end
      end
      if (d8_vld && d8_irdy) begin s.din = d8_din; s.tag = d8_tag; q8.push_back(s); end
      if (d32_ovld) begin
        d32_cnt++;
        if (q32.size() != 0) begin
          s = q32.pop_front();
          f = isqrt(s.din);
          check_val("d32_root", d32_root, f);
          check_val("d32_rem", d32_rem, s.din - f * f);
          check_val("d32_tag", d32_otag, s.tag);
        end
      end
      if (d32_vld && d32_irdy) begin s.din = d32_din; s.tag = d32_tag; q32.push_back(s); end
    end
  end

  initial begin
    int unsigned k;
    d8_vld = 1'b0; d8_din = '0; d8_tag = '0;
    d32_vld = 1'b0; d32_din = '0; d32_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst_aux = 1'b0;
    for (int v = 0; v < 256; v++) begin
      d8_vld = 1'b1; d8_din = 8'(v); d8_tag = 8'(v * 7);
      @(posedge clk); #1;
    end
    d8_vld = 1'b0;
    for (int i = 0; i < 253; i++) begin
      if (i == 0) d32_din = 32'h0;
      else if (i == 1) d32_din = 32'hFFFF_FFFF;
      else if (i == 2) d32_din = 32'hFFFE_0001;
      else if (i < 103) begin
        k = $urandom_range(65535, 1);
        d32_din = (i % 2 == 1) ? k * k : k * k - 1;
      end else d32_din = $urandom;
      d32_vld = 1'b1; d32_tag = 8'($urandom);
      d32_sent++;
      @(posedge clk); #1;
    end
    d32_vld = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_val("d8_count", d8_cnt, 256);
    check_val("d8_drained", q8.size(), 0);
    check_val("d32_count", d32_cnt, d32_sent);
    check_val("d32_drained", q32.size(), 0);
    aux_done = 1'b1;
  end

  // ---------------- main sequence ----------------
  initial begin
    int c0;
    din_vld = 1'b0; din = '0; tag = '0; dout_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_valid", dout_vld, 0);
    check_val("reset_root", root, 0);
    check_val("reset_rem", rem, 0);
    check_val("reset_tag", otag, 0);
    check_val("reset_rnd_valid", r_dout_vld, 0);
    rst = 1'b0;

    single(16'd0,     8'h11, 8'd0,   9'd0,   8'd0,   "in0");
    single(16'd1,     8'h22, 8'd1,   9'd0,   8'd1,   "in1");
    single(16'd24,    8'h33, 8'd4,   9'd8,   8'd5,   "in24");
    single(16'd65535, 8'h44, 8'd255, 9'd510, 8'd255, "in65535");
    single(16'd20,    8'h55, 8'd4,   9'd4,   8'd4,   "in20");
    single(16'd65280, 8'h66, 8'd255, 9'd255, 8'd255, "in65280");

    // Back-to-back stream with the sink always ready.
    first_out_cyc = -1;
    c0 = out_cnt;
    dout_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      din_vld = 1'b1; din = 16'($urandom); tag = 8'($urandom);
      @(posedge clk); #1;
    end
    din_vld = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_val("stream_count", out_cnt - c0, 1000);
    check_val("stream_contiguous", last_out_cyc - first_out_cyc, 999);
    check_val("stream_drained", sb.size(), 0);

    // Random input gaps and random downstream stalls.
    for (int i = 0; i < 2000; i++) begin
      din_vld = ($urandom_range(2, 0) != 0);
      dout_rdy = 1'($urandom);
      din = 16'($urandom); tag = 8'($urandom);
      @(posedge clk); #1;
    end
    din_vld = 1'b0; dout_rdy = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_val("random_drained", sb.size(), 0);
    check_val("no_duplicates", n_extra, 0);

    // Fill while stalled, then reset in the middle of the stall.
    dout_rdy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      din_vld = 1'b1; din = 16'($urandom); tag = 8'($urandom);
      @(posedge clk); #1;
    end
    check_val("full_valid", dout_vld, 1);
    check_val("full_din_ready", din_rdy, 0);
    din_vld = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    din_vld = 1'b1; din = 16'd144; tag = 8'h5a; dout_rdy = 1'b1;
    check_val("postrst_valid", dout_vld, 0);
    check_val("postrst_root", root, 0);
    check_val("postrst_rem", rem, 0);
    check_val("postrst_tag", otag, 0);
    check_val("postrst_rnd_valid", r_dout_vld, 0);
    check_val("postrst_din_ready", din_rdy, 1);
    @(posedge clk); #1;
    din_vld = 1'b0;
    wait_result("in144");
    check_val("in144_root", root, 12);
    check_val("in144_rem", rem, 0);
    check_val("in144_tag", otag, 8'h5a);
    check_val("in144_rnd_root", r_root, 12);
    @(posedge clk); #1;

    for (int i = 0; i < 2000 && !aux_done; i++) @(posedge clk);
    check_val("aux_done", aux_done, 1);
    check_val("no_duplicates_final", n_extra, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sqrt_pipeline_stream.md
# sqrt_pipeline_stream

Parametrised, fully pipelined integer square-root unit with valid/ready flow control, a per-sample sideband tag, remainder output and selectable floor/round mode. It computes one result bit per stage using the restoring digit-by-digit method and accepts one sample per clock. It sits in the guideir_ptic datapath next to the existing sqrt pipeline and serves magnitude and RMS calculations in the image-statistics chain.

## Interface
- DW, 16: radicand width. Must be even and ≥4; an odd value is an elaboration error. N = DW/2.
- TW, 8: sideband tag width, ≥1.
- ROUND_EN, 0: 0 = floor(sqrt), 1 = round-to-nearest with saturation.
- i_Sys_clk  in  1  single clock; all logic on its rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_Din_valid  in  1  input sample valid.
- i_Din  in  DW  unsigned radicand.
- i_Tag  in  TW  sideband carried alongside the sample.
- o_Din_ready  out  1  input accepted when i_Din_valid & o_Din_ready.
- o_Dout_valid  out  1  result valid.
- i_Dout_ready  in  1  downstream accepts the result.
- o_Root  out  N  square root (floor, or rounded per ROUND_EN).
- o_Rem  out  N+1  floor remainder, i_Din − floor_root².
- o_Tag  out  TW  tag of the sample that produced this result.

## Operation
- Pipeline has N register stages, S0..SN-1. Each stage holds valid, root (N), rem (N+1), the remaining radicand bits (DW) and the tag.
- Stage k: r = (rem<<2) | next two MSBs of the radicand, taken with the radicand shifted left by 2. Trial t = (root<<2) | 1 at N+2 bits. If r ≥ t, then rem = r − t and root = (root<<1) | 1; otherwise rem = r and root = root<<1. S0 starts from root = 0 and rem = 0.
- All compares and subtracts use N+2 bits with no truncation. The remainder fits in N+1 bits because it is at most 2·root.
- Output comes from SN-1. o_Rem is always the floor remainder.
- When ROUND_EN=1, the rounding is folded into the SN-1 register with no extra latency. If rem > root, root_out = root + 1; otherwise root_out = root. If root = 2^N−1 and rem > root, root_out saturates to 2^N−1.
- Flow control: advance = ~o_Dout_valid | i_Dout_ready, and o_Din_ready = advance (combinational).
  - When advance=1, every stage loads from its predecessor. S0 loads valid = i_Din_valid.
  - When advance=0, every stage holds, including its valid bits and data.
  - Bubbles are not collapsed.
- Data and tag registers of invalid stages may hold any value. Only the valid bits must be reset.
- Reset: when i_Rst=1 at a clock edge, all stage valid bits clear, and o_Dout_valid = 0 on the next cycle. In-flight samples are discarded with no partial output. o_Root, o_Rem and o_Tag reset to 0.
- Reset mid-stall: reset overrides the hold. After release, the pipeline accepts a new sample on the first cycle.

## Timing
- Latency is N cycles. A sample accepted at edge T appears with o_Dout_valid=1 after edge T+N−1, provided advance stays 1.
- Throughput is 1 sample/clock with sustained i_Dout_ready=1.
- With i_Dout_ready=0 and o_Dout_valid=1, outputs and o_Tag stay stable every cycle until the handshake completes.
- o_Din_ready depends combinationally on i_Dout_ready and o_Dout_valid. There is no path from i_Din_valid to o_Din_ready.
- Each stage holds at most one N+2-bit compare/subtract. Target Fmax ≥ 150 MHz at DW=16 on the K7 device.

## Test plan
- DW=16, ROUND_EN=0, single samples. Inputs 0, 1, 24, 65535 must produce root/rem of 0/0, 1/0, 4/8 and 255/510 respectively, each 8 cycles after accept. Tags 0x11, 0x22, 0x33, 0x44 must be echoed.
- ROUND_EN=1:
  - 24 → 5 (rem 8).
  - 20 → 4 (rem 4, not rounded).
  - 65535 → 255 saturated (rem 510).
  - 65280 → 255 (rem 255, not rounded).
- Back-to-back stream of 1000 random values with i_Dout_ready=1:
  - one result per clock in order;
  - root² + rem = din and rem ≤ 2·root for every result;
  - tags match.
- Random i_Dout_ready (50%) and random i_Din_valid gaps:
  - no loss or duplication;
  - outputs stable while stalled;
  - o_Din_ready equals ~o_Dout_valid | i_Dout_ready every cycle.
- Fill the pipeline, hold i_Dout_ready=0, then assert i_Rst for 1 cycle:
  - o_Dout_valid=0 on the next cycle and outputs are 0;
  - a new sample 144 is accepted on the first cycle after reset and returns root 12, rem 0.
- DW=8 and DW=32 builds: exhaustive test at DW=8; random and corner inputs (0, 2^32−1, k² and k²−1) at DW=32 against a reference model.
